// File: rtl/mem_access_stage.sv
// Memory-access stage controller between EX/MEM and MEM/WB.
// Issues loads/stores over a req/ack handshake, stalls upstream while an
// access is outstanding, bubbles MEM/WB until the result is ready, and flags
// misaligned doubleword accesses and timed-out requests with a one-cycle error.
module mem_access_stage #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic        Size_in,
  input  logic [63:0] Address_in,
  input  logic [63:0] StoreData_in,
  input  logic [63:0] ALU_Result_in,
  input  logic [63:0] LSR_Result_in,
  input  logic [4:0]  Rd_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  MemToReg_in,
  output logic        stall_out,
  output logic [63:0] ReadData_out,
  output logic [63:0] ALU_Result_out,
  output logic [63:0] LSR_Result_out,
  output logic [4:0]  Rd_out,
  output logic        RegWrite_out,
  output logic [1:0]  MemToReg_out,
  output logic        err_out,
  output logic        dm_req,
  output logic        dm_we,
  output logic        dm_size,
  output logic [63:0] dm_addr,
  output logic [63:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [63:0] dm_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Last wait-counter value before the access is declared timed out.
  localparam logic [7:0] W_LAST = 8'(MAX_WAIT - 1);

  state_t      state_q;
  logic [63:0] h_addr_q, h_wdata_q, h_alu_q, h_lsr_q;
  logic [4:0]  h_rd_q;
  logic        h_regwrite_q, h_memread_q, h_memwrite_q, h_size_q;
  logic [1:0]  h_memtoreg_q;
  logic [63:0] r_q;
  logic        e_q;
  logic [7:0]  w_q;
  logic        dm_req_q;

  logic        mem_op_s;
  logic        misalign_s;
  logic [63:0] rdata_d;

  // Classify the incoming instruction and shape read data by access size.
  always_comb begin
    mem_op_s   = valid_in & (MemRead_in | MemWrite_in);
    misalign_s = Size_in & (Address_in[2:0] != 3'd0);
    if (h_size_q) begin
      rdata_d = dm_rdata;
    end else begin
      rdata_d = {56'd0, dm_rdata[7:0]};
    end
  end

  // Control FSM with hold registers, result/error capture and wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      h_addr_q     <= 64'd0;
      h_wdata_q    <= 64'd0;
      h_alu_q      <= 64'd0;
      h_lsr_q      <= 64'd0;
      h_rd_q       <= 5'd0;
      h_regwrite_q <= 1'b0;
      h_memtoreg_q <= 2'd0;
      h_memread_q  <= 1'b0;
      h_memwrite_q <= 1'b0;
      h_size_q     <= 1'b0;
      r_q          <= 64'd0;
      e_q          <= 1'b0;
      w_q          <= 8'd0;
      dm_req_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mem_op_s) begin
            h_addr_q     <= Address_in;
            h_wdata_q    <= StoreData_in;
            h_alu_q      <= ALU_Result_in;
            h_lsr_q      <= LSR_Result_in;
            h_rd_q       <= Rd_in;
            h_regwrite_q <= RegWrite_in;
            h_memtoreg_q <= MemToReg_in;
            h_memread_q  <= MemRead_in;
            h_memwrite_q <= MemWrite_in;
            h_size_q     <= Size_in;
            w_q          <= 8'd0;
            if (misalign_s) begin
              e_q     <= 1'b1;
              state_q <= DONE;
            end else begin
              e_q      <= 1'b0;
              dm_req_q <= 1'b1;
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (dm_ack) begin
            r_q      <= rdata_d;
            dm_req_q <= 1'b0;
            state_q  <= DONE;
          end else begin
            w_q <= w_q + 8'd1;
            if (w_q == W_LAST) begin
              e_q      <= 1'b1;
              r_q      <= 64'd0;
              dm_req_q <= 1'b0;
              state_q  <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          dm_req_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  // Memory request payload comes straight from the hold registers.
  assign dm_req   = dm_req_q;
  assign dm_we    = h_memwrite_q;
  assign dm_size  = h_size_q;
  assign dm_addr  = h_addr_q;
  assign dm_wdata = h_wdata_q;

  // MEM/WB-facing outputs: pass-through in IDLE, bubble in BUSY, result in DONE.
  always_comb begin
    stall_out      = mem_op_s;
    ReadData_out   = 64'd0;
    ALU_Result_out = ALU_Result_in;
    LSR_Result_out = LSR_Result_in;
    Rd_out         = Rd_in;
    MemToReg_out   = MemToReg_in;
    RegWrite_out   = RegWrite_in & valid_in & ~mem_op_s;
    err_out        = 1'b0;
    case (state_q)
      IDLE: begin
        stall_out = mem_op_s;
      end
      BUSY: begin
        stall_out      = 1'b1;
        ALU_Result_out = h_alu_q;
        LSR_Result_out = h_lsr_q;
        Rd_out         = h_rd_q;
        MemToReg_out   = h_memtoreg_q;
        RegWrite_out   = 1'b0;
      end
      DONE: begin
        stall_out      = 1'b0;
        ReadData_out   = r_q;
        ALU_Result_out = h_alu_q;
        LSR_Result_out = h_lsr_q;
        Rd_out         = h_rd_q;
        MemToReg_out   = h_memtoreg_q;
        RegWrite_out   = h_regwrite_q & ~e_q;
        err_out        = e_q;
      end
      default: begin
        stall_out = mem_op_s;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed and randomized bench for mem_access_stage with a transaction-level
// reference model (expected latency, data, error and writeback per access).
module tb_mem_access_stage;

  localparam int MW = 4;

  logic        clk, reset;
  logic        valid_in, MemRead_in, MemWrite_in, Size_in;
  logic [63:0] Address_in, StoreData_in, ALU_Result_in, LSR_Result_in;
  logic [4:0]  Rd_in;
  logic        RegWrite_in;
  logic [1:0]  MemToReg_in;
  logic        stall_out;
  logic [63:0] ReadData_out, ALU_Result_out, LSR_Result_out;
  logic [4:0]  Rd_out;
  logic        RegWrite_out;
  logic [1:0]  MemToReg_out;
  logic        err_out;
  logic        dm_req, dm_we, dm_size;
  logic [63:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;

  int checks = 0;
  int failures = 0;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .Size_in(Size_in),
    .Address_in(Address_in), .StoreData_in(StoreData_in),
    .ALU_Result_in(ALU_Result_in), .LSR_Result_in(LSR_Result_in),
    .Rd_in(Rd_in), .RegWrite_in(RegWrite_in), .MemToReg_in(MemToReg_in),
    .stall_out(stall_out), .ReadData_out(ReadData_out),
    .ALU_Result_out(ALU_Result_out), .LSR_Result_out(LSR_Result_out),
    .Rd_out(Rd_out), .RegWrite_out(RegWrite_out), .MemToReg_out(MemToReg_out),
    .err_out(err_out), .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    valid_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; Size_in = 1'b0;
    RegWrite_in = 1'b0;
  endtask

  // Non-memory op: results must appear in the same cycle with no stall.
  task automatic alu_op(input logic v, input logic rw, input logic [4:0] rd,
                        input logic [63:0] alu);
    logic [63:0] lsr;
    logic [1:0]  m2r;
    lsr = rnd64();
    m2r = 2'($urandom_range(0, 3));
    valid_in = v; MemRead_in = 1'b0; MemWrite_in = 1'b0; Size_in = 1'($urandom_range(0, 1));
    Address_in = rnd64(); StoreData_in = rnd64();
    ALU_Result_in = alu; LSR_Result_in = lsr; Rd_in = rd; RegWrite_in = rw; MemToReg_in = m2r;
    #1;
    check("alu_stall", 64'(stall_out), 64'd0);
    check("alu_regwrite", 64'(RegWrite_out), 64'(v & rw));
    check("alu_rd", 64'(Rd_out), 64'(rd));
    check("alu_result", ALU_Result_out, alu);
    check("alu_lsr", LSR_Result_out, lsr);
    check("alu_m2r", 64'(MemToReg_out), 64'(m2r));
    check("alu_readdata", ReadData_out, 64'd0);
    check("alu_dmreq", 64'(dm_req), 64'd0);
    check("alu_err", 64'(err_out), 64'd0);
    @(posedge clk); #1;
  endtask

  // Memory op; ack arrives in BUSY cycle k (k > MW means never).
  task automatic mem_op(input logic wr, input logic size, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata, input int k);
    logic        misal, tmo, exp_err, exp_rw;
    logic [63:0] exp_data, alu;
    logic [4:0]  rd;
    logic [1:0]  m2r;
    int          busy;
    misal    = size && (addr[2:0] != 3'd0);
    tmo      = !misal && (k > MW);
    exp_err  = misal || tmo;
    exp_rw   = !wr && !exp_err;
    exp_data = tmo ? 64'd0 : (size ? rdata : (rdata & 64'h0000_0000_0000_00FF));
    rd  = 5'($urandom_range(0, 31));
    alu = rnd64();
    m2r = 2'($urandom_range(0, 3));
    valid_in = 1'b1; MemRead_in = !wr; MemWrite_in = wr; Size_in = size;
    Address_in = addr; StoreData_in = wdata; ALU_Result_in = alu;
    LSR_Result_in = rnd64(); Rd_in = rd; RegWrite_in = !wr; MemToReg_in = m2r;
    dm_ack = 1'b0;
    #1;
    check("issue_stall", 64'(stall_out), 64'd1);
    check("issue_bubble", 64'(RegWrite_out), 64'd0);
    check("issue_dmreq", 64'(dm_req), 64'd0);
    busy = 0;
    if (!misal) begin
      for (int c = 1; c <= MW; c++) begin
        @(posedge clk); #1;
        busy++;
        check("busy_dmreq", 64'(dm_req), 64'd1);
        check("busy_addr", dm_addr, addr);
        check("busy_we", 64'(dm_we), 64'(wr));
        check("busy_size", 64'(dm_size), 64'(size));
        check("busy_wdata", dm_wdata, wdata);
        check("busy_stall", 64'(stall_out), 64'd1);
        check("busy_bubble", 64'(RegWrite_out), 64'd0);
        if (c == k) begin
          dm_ack = 1'b1; dm_rdata = rdata;
          break;
        end else begin
          dm_ack = 1'b0; dm_rdata = rnd64();
        end
      end
    end
    check("busy_cycles", 64'(busy), misal ? 64'd0 : (tmo ? 64'(MW) : 64'(k)));
    @(posedge clk); #1;
    dm_ack = 1'b0; dm_rdata = rnd64();
    check("done_stall", 64'(stall_out), 64'd0);
    check("done_dmreq", 64'(dm_req), 64'd0);
    check("done_err", 64'(err_out), 64'(exp_err));
    check("done_regwrite", 64'(RegWrite_out), 64'(exp_rw));
    check("done_rd", 64'(Rd_out), 64'(rd));
    check("done_alu", ALU_Result_out, alu);
    check("done_m2r", 64'(MemToReg_out), 64'(m2r));
    if (!wr && !misal) check("done_readdata", ReadData_out, exp_data);
    idle_inputs();
    @(posedge clk); #1;
    check("post_err", 64'(err_out), 64'd0);
    check("post_stall", 64'(stall_out), 64'd0);
  endtask

  initial begin
    int kind;
    logic [63:0] a;
    reset = 1'b0;
    idle_inputs();
    Address_in = 64'd0; StoreData_in = 64'd0; ALU_Result_in = 64'd0;
    LSR_Result_in = 64'd0; Rd_in = 5'd0; MemToReg_in = 2'd0;
    dm_ack = 1'b0; dm_rdata = 64'd0;
    #1;
    check("rst_dmreq", 64'(dm_req), 64'd0);
    check("rst_we", 64'(dm_we), 64'd0);
    check("rst_addr", dm_addr, 64'd0);
    check("rst_wdata", dm_wdata, 64'd0);
    check("rst_stall", 64'(stall_out), 64'd0);
    check("rst_err", 64'(err_out), 64'd0);
    @(posedge clk); @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Directed test-plan items.
    alu_op(1'b1, 1'b1, 5'd5, 64'h2A);
    mem_op(1'b0, 1'b1, 64'h40, 64'd0, 64'h1122_3344_5566_7788, 1);
    mem_op(1'b0, 1'b0, 64'h43, 64'd0, 64'hFFFF_FFFF_FFFF_FF9C, 3);
    mem_op(1'b0, 1'b1, 64'h44, 64'd0, 64'd0, 1);
    mem_op(1'b1, 1'b1, 64'h80, 64'hDEAD_BEEF_0123_4567, 64'd0, MW + 1);
    // Late ack after timeout must be ignored.
    dm_ack = 1'b1; dm_rdata = rnd64();
    @(posedge clk); #1;
    dm_ack = 1'b0;
    check("late_ack_dmreq", 64'(dm_req), 64'd0);
    check("late_ack_err", 64'(err_out), 64'd0);
    check("late_ack_stall", 64'(stall_out), 64'd0);

    // Reset in the middle of a BUSY access.
    valid_in = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; Size_in = 1'b1;
    Address_in = 64'h100; RegWrite_in = 1'b1;
    @(posedge clk); #1;
    check("rstbusy_dmreq_before", 64'(dm_req), 64'd1);
    #3;
    reset = 1'b0;
    #1;
    check("rstbusy_dmreq_async", 64'(dm_req), 64'd0);
    check("rstbusy_addr", dm_addr, 64'd0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    alu_op(1'b1, 1'b1, 5'd9, 64'h1234);

    // Randomized transactions.
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      a = rnd64();
      case (kind)
        0: alu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), rnd64());
        1: mem_op(1'b0, 1'b1, {a[63:3], 3'd0}, rnd64(), rnd64(), $urandom_range(1, MW + 1));
        2: mem_op(1'b0, 1'b0, a, rnd64(), rnd64(), $urandom_range(1, MW + 1));
        3: mem_op(1'b1, 1'($urandom_range(0, 1)), {a[63:3], 3'd0}, rnd64(), rnd64(),
                  $urandom_range(1, MW + 1));
        default: mem_op(1'($urandom_range(0, 1)), 1'b1, {a[63:3], 3'($urandom_range(1, 7))},
                        rnd64(), rnd64(), 1);
      endcase
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
